// File: rtl/bus_req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_req_ack_responder
// Brief    : Single-outstanding bus responder. It acknowledges each request
//            after a programmable number of wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bus_req_ack_responder #(
    parameter int DATA_W = 32,
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [LAT_W-1:0]  cfg_latency,
    input  logic              err_clear,
    output logic              bus_ack,
    output logic [DATA_W-1:0] ack_data,
    output logic              busy,
    output logic              err_overlap,
    output logic [7:0]        txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] c_lat_zero = '0;
    localparam logic [LAT_W-1:0] c_lat_one  = LAT_W'(1);

    state_t              r_state;
    logic [LAT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_ack_data;
    logic                r_bus_ack;
    logic                r_busy;
    logic                r_err_overlap;
    logic [7:0]          r_txn_count;

    state_t              w_state_nxt;
    logic [LAT_W-1:0]    w_count_nxt;
    logic                w_accept;
    logic                w_overlap;

    // A request is only taken when no transaction occupies the WAIT phase;
    // the ACK cycle can accept so back-to-back traffic needs no idle gap.
    assign w_accept  = bus_req && (r_state == ST_IDLE || r_state == ST_ACK);
    assign w_overlap = bus_req && (r_state == ST_WAIT);

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE, ST_ACK: begin
                if (w_accept) begin
                    w_count_nxt = cfg_latency;
                    w_state_nxt = (cfg_latency == c_lat_zero) ? ST_ACK : ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_count <= c_lat_one) begin
                    w_count_nxt = c_lat_zero;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_count_nxt = r_count - c_lat_one;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_count_nxt = c_lat_zero;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_count       <= c_lat_zero;
            r_ack_data    <= '0;
            r_bus_ack     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_overlap <= 1'b0;
            r_txn_count   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_bus_ack <= (w_state_nxt == ST_ACK);
            r_busy    <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ACK);
            if (w_accept) begin
                r_ack_data <= bus_data;
            end
            if (w_state_nxt == ST_ACK) begin
                r_txn_count <= r_txn_count + 8'd1;
            end
            if (w_overlap) begin
                r_err_overlap <= 1'b1;
            end else if (err_clear) begin
                r_err_overlap <= 1'b0;
            end
        end
    end

    assign bus_ack     = r_bus_ack;
    assign ack_data    = r_ack_data;
    assign busy        = r_busy;
    assign err_overlap = r_err_overlap;
    assign txn_count   = r_txn_count;

endmodule
`default_nettype wire

// File: doc/bus_req_ack_responder.md
BUS_REQ_ACK_RESPONDER -- requirements
Module: bus_req_ack_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the request data width in bits.
REQ-002 The block SHALL have parameter LAT_W, default 4, giving the width of the latency configuration input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port bus_req, input, 1 bit: request strobe, a single-cycle pulse per transaction.
REQ-006 The block SHALL have port bus_data, input, DATA_W bits: request payload, valid in the bus_req cycle.
REQ-007 The block SHALL have port cfg_latency, input, LAT_W bits: extra wait cycles before the acknowledge.
REQ-008 The block SHALL have port err_clear, input, 1 bit: clears the sticky error flag.
REQ-009 The block SHALL have port bus_ack, output, 1 bit: acknowledge, a single-cycle pulse per accepted request.
REQ-010 The block SHALL have port ack_data, output, DATA_W bits: payload captured from the accepted request, held stable between acceptances.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in the WAIT or ACK state.
REQ-012 The block SHALL have port err_overlap, output, 1 bit: sticky protocol-violation flag.
REQ-013 The block SHALL have port txn_count, output, 8 bits: count of acknowledges issued.

Function
REQ-014 The block SHALL implement a three-state machine with states IDLE, WAIT and ACK; bus_ack SHALL be high exactly when the state is ACK.
REQ-015 In IDLE, a sampled bus_req=1 SHALL be accepted: capture bus_data into ack_data, load the down-counter with cfg_latency, and move to WAIT if cfg_latency>0, else to ACK.
REQ-016 cfg_latency SHALL be sampled only at acceptance; changes during WAIT SHALL NOT affect the transaction in flight.
REQ-017 In WAIT, the counter SHALL decrement each cycle and the state SHALL move to ACK in the cycle after the counter reaches 1.
REQ-018 A request accepted at edge N SHALL produce bus_ack high during cycle N+1+cfg_latency (latency 0: ack in the cycle after the request).
REQ-019 In ACK, the state SHALL return to IDLE unless bus_req=1 in that same cycle; a coincident bus_req SHALL be accepted per REQ-015, so back-to-back transactions are supported with no idle gap.
REQ-020 Each ACK cycle SHALL increment txn_count by 1, modulo 256 (255 wraps to 0).
REQ-021 A bus_req=1 sampled in WAIT SHALL be ignored: no capture and no counter reload, and err_overlap SHALL be set to 1.
REQ-022 err_overlap SHALL stay set until err_clear=1; if set and clear occur in the same cycle, set SHALL win.
REQ-023 ack_data SHALL change only at acceptance and SHALL NOT change while bus_ack is high.
REQ-024 The outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-025 With reset=1 at a clock edge, the state SHALL go to IDLE, and bus_ack, busy and err_overlap SHALL go to 0, txn_count to 0, ack_data to 0 and the counter to 0.
REQ-026 reset SHALL take priority over every other input, including a bus_req in the same cycle and a transaction in WAIT or ACK, which SHALL be dropped with no ack.
REQ-027 A bus_req in the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-028 Scenario: cfg_latency=0, bus_req pulse at cycle 5 with bus_data=32'hfeed -> bus_ack high in cycle 6 only, ack_data=32'hfeed, txn_count=1.
REQ-029 Scenario: cfg_latency=3, bus_req at cycle 10 -> busy high in cycles 11-14, bus_ack high in cycle 14 only; cfg_latency changed to 0 at cycle 12 -> no effect on that transaction.
REQ-030 Scenario: cfg_latency=2, bus_req at cycle 0, then a second bus_req in the ACK cycle (cycle 3) with data 32'h2 -> acks at cycles 3 and 6, ack_data=32'h2 after the second acceptance, err_overlap=0.
REQ-031 Scenario: cfg_latency=4, a second bus_req during WAIT -> exactly one ack, data from the first request, err_overlap=1; err_clear pulse -> 0; err_clear coincident with a new overlap -> remains 1.
REQ-032 Scenario: reset asserted during WAIT -> no ack, all outputs 0 next cycle; 256 transactions -> txn_count wraps to 0.
